control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/reg_sel_decoder.sv | 9 +
 rtl/control_sequencer.sv | 116 +++++++++++
 tb/tb_control_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared states, bit indices, opcodes and ALU codes for the control sequencer
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_T8    = 4'd9,
        S_HALT  = 4'd10,
        S_FAULT = 4'd11
    } state_t;

    localparam int EN_HI      = 16;
    localparam int EN_LO      = 17;
    localparam int EN_ZHI     = 18;
    localparam int EN_ZLO     = 19;
    localparam int EN_PC      = 20;
    localparam int EN_MDR     = 21;
    localparam int EN_INPORT  = 22;
    localparam int EN_IR      = 23;
    localparam int EN_Z       = 24;
    localparam int EN_MAR     = 25;
    localparam int EN_OUTPORT = 26;
    localparam int EN_Y       = 27;

    localparam int BS_HI     = 16;
    localparam int BS_LO     = 17;
    localparam int BS_ZHI    = 18;
    localparam int BS_ZLO    = 19;
    localparam int BS_PC     = 20;
    localparam int BS_MDR    = 21;
    localparam int BS_INPORT = 22;
    localparam int BS_C      = 23;

    localparam logic [4:0] OP_RMAX = 5'h07;
    localparam logic [4:0] OP_ADDI = 5'h08;
    localparam logic [4:0] OP_LD   = 5'h09;
    localparam logic [4:0] OP_ST   = 5'h0A;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_INC = 4'd8;

    function automatic logic [31:0] bit32(input int idx);
        return 32'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// reg_sel_decoder: 4-bit register index to 16-bit one-hot select
module reg_sel_decoder (
    input  logic [3:0]  i_idx,
    output logic [15:0] o_sel
);

    assign o_sel = 16'(1) << i_idx;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute control FSM for the register datapath
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [3:0]  Control_Signals,
    output logic        MR_Read,
    output logic        mem_write,
    output logic        done,
    output logic        fault,
    output logic [3:0]  state_dbg
);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  w_op;
    logic [15:0] w_ra_sel;
    logic [15:0] w_rb_sel;
    logic [15:0] w_rc_sel;
    logic        w_is_r;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_legal;
    logic        w_unused;

    assign w_op     = ir[31:27];
    assign w_is_r   = w_op <= OP_RMAX;
    assign w_is_ld  = w_op == OP_LD;
    assign w_is_st  = w_op == OP_ST;
    assign w_legal  = w_op <= OP_ST;
    assign w_unused = ^ir[14:0];
    assign state_dbg = r_state;

    reg_sel_decoder u_ra (.i_idx(ir[26:23]), .o_sel(w_ra_sel));
    reg_sel_decoder u_rb (.i_idx(ir[22:19]), .o_sel(w_rb_sel));
    reg_sel_decoder u_rc (.i_idx(ir[18:15]), .o_sel(w_rc_sel));

    // state register; clr wins over every other input
    always_ff @(posedge clk) begin
        r_state <= clr ? S_IDLE : w_next;
    end

    // next state and all control outputs from current state and ir
    always_comb begin
        w_next          = r_state;
        busSelect       = '0;
        enable          = '0;
        Control_Signals = ALU_ADD;
        MR_Read         = 1'b0;
        mem_write       = 1'b0;
        done            = 1'b0;
        fault           = 1'b0;
        case (r_state)
            S_IDLE: w_next = run ? S_T0 : S_IDLE;
            S_T0: begin
                busSelect       = bit32(BS_PC);
                enable          = bit32(EN_MAR) | bit32(EN_Z);
                Control_Signals = ALU_INC;
                w_next          = S_T1;
            end
            S_T1: begin
                busSelect = bit32(BS_ZLO);
                enable    = bit32(EN_PC);
                w_next    = S_T2;
            end
            S_T2: begin
                MR_Read = 1'b1;
                enable  = mem_ready ? bit32(EN_MDR) : '0;
                w_next  = mem_ready ? S_T3 : S_T2;
            end
            S_T3: begin
                busSelect = bit32(BS_MDR);
                enable    = bit32(EN_IR);
                w_next    = S_T4;
            end
            S_T4: begin
                busSelect = w_legal ? {16'b0, w_rb_sel} : '0;
                enable    = w_legal ? bit32(EN_Y) : '0;
                w_next    = w_legal ? S_T5 : (w_op == OP_HALT) ? S_HALT : S_FAULT;
            end
            S_T5: begin
                busSelect       = w_is_r ? {16'b0, w_rc_sel} : bit32(BS_C);
                Control_Signals = w_is_r ? {1'b0, w_op[2:0]} : ALU_ADD;
                enable          = bit32(EN_Z);
                w_next          = S_T6;
            end
            S_T6: begin
                busSelect = bit32(BS_ZLO);
                enable    = (w_is_ld || w_is_st) ? bit32(EN_MAR) : {16'b0, w_ra_sel};
                w_next    = (w_is_ld || w_is_st) ? S_T7 : S_T0;
            end
            S_T7: begin
                busSelect = w_is_st ? {16'b0, w_ra_sel} : '0;
                enable    = (w_is_st || mem_ready) ? bit32(EN_MDR) : '0;
                MR_Read   = !w_is_st;
                w_next    = (w_is_st || mem_ready) ? S_T8 : S_T7;
            end
            S_T8: begin
                busSelect = w_is_st ? '0 : bit32(BS_MDR);
                enable    = w_is_st ? '0 : {16'b0, w_ra_sel};
                mem_write = w_is_st;
                w_next    = (!w_is_st || mem_ready) ? S_T0 : S_T8;
            end
            S_HALT:  done  = 1'b1;
            S_FAULT: fault = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks against an instruction-level microstep model
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        run = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [3:0]  Control_Signals;
    logic        MR_Read;
    logic        mem_write;
    logic        done;
    logic        fault;
    logic [3:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        state_t      st;
        logic [31:0] ir;
        logic [31:0] bus;
        logic [31:0] en;
        logic [3:0]  alu;
        logic        mr;
        logic        mw;
        logic        dn;
        logic        ft;
        logic        rdy;
        logic        run;
    } beat_t;

    beat_t q[$];

    control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
        .enable(enable), .busSelect(busSelect), .Control_Signals(Control_Signals),
        .MR_Read(MR_Read), .mem_write(mem_write), .done(done), .fault(fault),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] oh(input int k);
        return 32'(1) << k;
    endfunction

    function automatic beat_t bt(input state_t s, input logic [31:0] bus, input logic [31:0] en,
                                 input logic [3:0] alu, input logic mr, input logic mw, input logic rdy);
        beat_t b;
        b.st  = s;
        b.ir  = $urandom;
        b.bus = bus;
        b.en  = en;
        b.alu = alu;
        b.mr  = mr;
        b.mw  = mw;
        b.dn  = s == S_HALT;
        b.ft  = s == S_FAULT;
        b.rdy = rdy;
        b.run = 1'($urandom);
        return b;
    endfunction

    // expected cycle-by-cycle microsteps of one instruction, memory waits given explicitly
    task automatic build(input logic [31:0] i, input int w2, input int w7, input int w8, input bit from_idle);
        int op, ra, rb, rc, n0;
        beat_t b;
        op = int'(i[31:27]);
        ra = int'(i[26:23]);
        rb = int'(i[22:19]);
        rc = int'(i[18:15]);
        if (from_idle) begin
            b = bt(S_IDLE, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0);
            b.run = 1'b1;
            q.push_back(b);
        end
        q.push_back(bt(S_T0, oh(20), oh(25) | oh(24), 4'd8, 1'b0, 1'b0, 1'b0));
        q.push_back(bt(S_T1, oh(19), oh(20), 4'd0, 1'b0, 1'b0, 1'b0));
        repeat (w2) q.push_back(bt(S_T2, 0, 0, 4'd0, 1'b1, 1'b0, 1'b0));
        q.push_back(bt(S_T2, 0, oh(21), 4'd0, 1'b1, 1'b0, 1'b1));
        q.push_back(bt(S_T3, oh(21), oh(23), 4'd0, 1'b0, 1'b0, 1'b0));
        n0 = q.size();
        if (op > 10) begin
            q.push_back(bt(S_T4, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0));
            q.push_back(bt(op == 31 ? S_HALT : S_FAULT, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0));
        end else begin
            q.push_back(bt(S_T4, oh(rb), oh(27), 4'd0, 1'b0, 1'b0, 1'b0));
            q.push_back(bt(S_T5, op < 8 ? oh(rc) : oh(23), oh(24), op < 8 ? 4'(op) : 4'd0, 1'b0, 1'b0, 1'b0));
            q.push_back(bt(S_T6, oh(19), (op == 9 || op == 10) ? oh(25) : oh(ra), 4'd0, 1'b0, 1'b0, 1'b0));
            if (op == 9) begin
                repeat (w7) q.push_back(bt(S_T7, 0, 0, 4'd0, 1'b1, 1'b0, 1'b0));
                q.push_back(bt(S_T7, 0, oh(21), 4'd0, 1'b1, 1'b0, 1'b1));
                q.push_back(bt(S_T8, oh(21), oh(ra), 4'd0, 1'b0, 1'b0, 1'b0));
            end
            if (op == 10) begin
                q.push_back(bt(S_T7, oh(ra), oh(21), 4'd0, 1'b0, 1'b0, 1'b0));
                repeat (w8) q.push_back(bt(S_T8, 0, 0, 4'd0, 1'b0, 1'b1, 1'b0));
                q.push_back(bt(S_T8, 0, 0, 4'd0, 1'b0, 1'b1, 1'b1));
            end
        end
        for (int k = n0; k < q.size(); k++) q[k].ir = i;
    endtask

    // play the queued microsteps, comparing every output in every cycle
    task automatic exec();
        beat_t b;
        logic [75:0] obs, exp;
        while (q.size() > 0) begin
            b = q.pop_front();
            @(negedge clk);
            ir = b.ir;
            run = b.run;
            mem_ready = b.rdy;
            #1;
            obs = {state_dbg, busSelect, enable, Control_Signals, MR_Read, mem_write, done, fault};
            exp = {b.st, b.bus, b.en, b.alu, b.mr, b.mw, b.dn, b.ft};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL step st=%0d ir=%h: got %h want %h", b.st, b.ir, obs, exp);
            end
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        run = 1'($urandom);
        mem_ready = 1'($urandom);
        @(negedge clk);
        clr = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr = 1'b1;
        run = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({state_dbg, busSelect, enable, Control_Signals, MR_Read, mem_write, done, fault} !== 76'd0) begin
            n_fail++;
            $display("FAIL reset_prio: state=%0d bus=%h en=%h", state_dbg, busSelect, enable);
        end
        clr = 1'b0;
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (state_dbg !== 4'(S_IDLE) || enable !== 32'd0 || busSelect !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_hold: state=%0d want %0d", state_dbg, S_IDLE);
            end
        end
    endtask

    task automatic test_fetch_add();
        build(32'h00918000, 3, 0, 0, 1'b1);
        exec();
    endtask

    task automatic test_ld();
        build(32'h48918000, 1, 2, 0, 1'b0);
        exec();
    endtask

    task automatic test_st();
        build(32'h50918000, 0, 0, 3, 1'b0);
        exec();
    endtask

    task automatic test_halt();
        build(32'hF8000000, 0, 0, 0, 1'b0);
        exec();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            run = 1'b1;
            mem_ready = 1'($urandom);
            #1;
            n_tests++;
            if (done !== 1'b1 || state_dbg !== 4'(S_HALT) || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold: done=%b state=%0d want done=1 state=%0d", done, state_dbg, S_HALT);
            end
        end
        pulse_clr();
    endtask

    task automatic test_fault();
        build(32'hA8918000, 0, 0, 0, 1'b1);
        exec();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            run = 1'b1;
            #1;
            n_tests++;
            if (fault !== 1'b1 || state_dbg !== 4'(S_FAULT) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_hold: fault=%b state=%0d want fault=1 state=%0d", fault, state_dbg, S_FAULT);
            end
        end
        for (int k = 0; k < 4; k++) begin
            pulse_clr();
            build({5'($urandom_range(11, 30)), 27'($urandom)}, $urandom_range(0, 2), 0, 0, 1'b1);
            exec();
        end
        pulse_clr();
    endtask

    task automatic test_clr_mid_st();
        build(32'h50918000, 0, 0, 0, 1'b1);
        q[q.size() - 1].rdy = 1'b0;
        exec();
        clr = 1'b1;
        mem_ready = 1'b1;
        run = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if (state_dbg !== 4'(S_IDLE) || mem_write !== 1'b0 || enable !== 32'd0 || busSelect !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_in_t8: state=%0d mw=%b en=%h want state=%0d mw=0 en=0", state_dbg, mem_write, enable, S_IDLE);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (state_dbg !== 4'(S_IDLE)) begin
            n_fail++;
            $display("FAIL clr_stays_idle: state=%0d want %0d", state_dbg, S_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] i;
        pulse_clr();
        for (int k = 0; k < 30; k++) begin
            i = {5'($urandom_range(0, 10)), 27'($urandom)};
            build(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), k == 0);
        end
        exec();
    endtask

    initial begin
        test_reset();
        test_fetch_add();
        test_ld();
        test_st();
        test_halt();
        test_fault();
        test_clr_mid_st();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
